// File: rtl/cpu_pkg.sv
// Shared execute-stage constants: flag bus layout, condition encodings and widths.
package cpu_pkg;

    localparam int FLAGS_W = 5;
    localparam int COND_W  = 4;
    localparam int IT_W    = 8;

    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Q = 0;

    localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
    localparam logic [COND_W-1:0] COND_NE = 4'b0001;
    localparam logic [COND_W-1:0] COND_CS = 4'b0010;
    localparam logic [COND_W-1:0] COND_CC = 4'b0011;
    localparam logic [COND_W-1:0] COND_MI = 4'b0100;
    localparam logic [COND_W-1:0] COND_PL = 4'b0101;
    localparam logic [COND_W-1:0] COND_VS = 4'b0110;
    localparam logic [COND_W-1:0] COND_VC = 4'b0111;
    localparam logic [COND_W-1:0] COND_HI = 4'b1000;
    localparam logic [COND_W-1:0] COND_LS = 4'b1001;
    localparam logic [COND_W-1:0] COND_GE = 4'b1010;
    localparam logic [COND_W-1:0] COND_LT = 4'b1011;
    localparam logic [COND_W-1:0] COND_GT = 4'b1100;
    localparam logic [COND_W-1:0] COND_LE = 4'b1101;
    localparam logic [COND_W-1:0] COND_AL = 4'b1110;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator over the registered N, Z, C, V flags.
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:1] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        // NOTE: default assignment first so no path through the case can infer a latch.
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = z | (n != v);
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/flag_cond_unit.sv
// Execute-stage flag register, IT-block tracker and condition gate for write-enables.
module flag_cond_unit
    import cpu_pkg::*;
#(
    parameter int FLAGS_WIDTH = FLAGS_W,
    parameter int COND_WIDTH  = COND_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   valid_e,
    input  logic [COND_WIDTH-1:0]  cond_e,
    input  logic [1:0]             flag_write_e,
    input  logic                   q_write_e,
    input  logic                   clear_q,
    input  logic [FLAGS_WIDTH-1:0] alu_flags,
    input  logic                   it_start,
    input  logic [COND_WIDTH-1:0]  it_firstcond,
    input  logic [COND_WIDTH-1:0]  it_mask,
    input  logic                   reg_write_e,
    input  logic                   mem_write_e,
    input  logic                   pcsrc_e,
    output logic                   reg_write_g,
    output logic                   mem_write_g,
    output logic                   pcsrc_g,
    output logic                   cond_ex,
    output logic [FLAGS_WIDTH-1:0] flags,
    output logic                   carry_out,
    output logic                   it_active
);

    logic [IT_W-1:0]       it_state;
    logic [COND_WIDTH-1:0] eff_cond;
    logic                  cond_pass;
    logic                  gate;
    logic                  commit;

    assign it_active = |it_state[3:0];
    assign eff_cond  = it_active ? it_state[7:4] : cond_e;

    cond_check u_cond_check (
        .cond  (eff_cond),
        .flags (flags[FLAG_N:FLAG_V]),
        .pass  (cond_pass)
    );

    // The IT instruction itself always executes, whatever block it interrupts.
    assign cond_ex = it_start | cond_pass;

    assign gate        = cond_ex & valid_e & !flush;
    assign reg_write_g = reg_write_e & gate;
    assign mem_write_g = mem_write_e & gate;
    assign pcsrc_g     = pcsrc_e & gate;

    assign commit    = valid_e & !stall & !flush & cond_ex;
    assign carry_out = flags[FLAG_C];

    // NOTE: registers use non-blocking assignments and reset asynchronously so state clears without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= '0;
        end else if (commit) begin
            if (flag_write_e[1]) begin
                flags[FLAG_N] <= alu_flags[FLAG_N];
                flags[FLAG_Z] <= alu_flags[FLAG_Z];
            end
            if (flag_write_e[0]) begin
                flags[FLAG_C] <= alu_flags[FLAG_C];
                flags[FLAG_V] <= alu_flags[FLAG_V];
            end
            flags[FLAG_Q] <= (flags[FLAG_Q] & !clear_q) | (q_write_e & alu_flags[FLAG_Q]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            it_state <= '0;
        end else if (flush) begin
            it_state <= '0;
        end else if (stall) begin
            it_state <= it_state;
        end else if (valid_e && it_start) begin
            it_state <= {it_firstcond, it_mask};
        end else if (valid_e && it_active) begin
            // Condition base [7:5] stays; the mask and condition LSB shift together.
            if (it_state[2:0] == 3'b000) begin
                it_state <= '0;
            end else begin
                it_state[4:0] <= {it_state[3:0], 1'b0};
            end
        end
    end

endmodule
